// File: rtl/alu_pkg.sv
// Shared definitions for the lab-3 ALU timing harness.
//   OP_W  : operand width
//   RES_W : result width
//   SEL_W : opcode width
//   alu_op_e : the 16 ALU operations, encoded as the opcode value
package alu_pkg;

    localparam int OP_W  = 5;
    localparam int RES_W = 10;
    localparam int SEL_W = 4;

    typedef enum logic [SEL_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NAND = 4'd6,
        OP_NOR  = 4'd7,
        OP_XNOR = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_NOT  = 4'd11,
        OP_PASA = 4'd12,
        OP_PASB = 4'd13,
        OP_LT   = 4'd14,
        OP_ZERO = 4'd15
    } alu_op_e;

endpackage

// File: rtl/freq_alu.sv
// Purely combinational 5-bit ALU core.
//   a   : operand A (unsigned, 5 b)
//   b   : operand B (unsigned, 5 b)
//   sel : opcode (alu_op_e encoding)
//   res : 10-bit result; operands zero-extended, result wraps
module freq_alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic [SEL_W-1:0] sel,
    output logic [RES_W-1:0] res
);

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;
    logic [OP_W-1:0]  pad;

    assign a_ext = {{(RES_W-OP_W){1'b0}}, a};
    assign b_ext = {{(RES_W-OP_W){1'b0}}, b};
    assign pad   = '0;

    always_comb begin
        res = '0;
        case (alu_op_e'(sel))
            OP_ADD:  res = a_ext + b_ext;
            OP_SUB:  res = a_ext - b_ext;
            OP_MUL:  res = a_ext * b_ext;
            OP_AND:  res = {pad, a & b};
            OP_OR:   res = {pad, a | b};
            OP_XOR:  res = {pad, a ^ b};
            OP_NAND: res = {pad, ~(a & b)};
            OP_NOR:  res = {pad, ~(a | b)};
            OP_XNOR: res = {pad, ~(a ^ b)};
            // Only the low three bits of B form the shift amount.
            OP_SHL:  res = a_ext << b[2:0];
            OP_SHR:  res = a_ext >> b[2:0];
            OP_NOT:  res = {pad, ~a};
            OP_PASA: res = a_ext;
            OP_PASB: res = b_ext;
            OP_LT:   res = {{(RES_W-1){1'b0}}, (a < b)};
            OP_ZERO: res = '0;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/test_frequency.sv
// Register-wrapped ALU so every ALU path is register-to-register.
//   clock : rising-edge clock
//   reset : asynchronous, active-low clear of all registers
//   in    : operand sample, captured into A; previous A moves to B
//   S     : opcode, captured into S_q
//   out   : registered result alu(A, B, S_q)
module test_frequency
    import alu_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [OP_W-1:0]  in,
    input  logic [SEL_W-1:0] S,
    output logic [RES_W-1:0] out
);

    logic [OP_W-1:0]  a_q;
    logic [OP_W-1:0]  b_q;
    logic [SEL_W-1:0] s_q;
    logic [RES_W-1:0] alu_res;

    freq_alu u_alu (
        .a   (a_q),
        .b   (b_q),
        .sel (s_q),
        .res (alu_res)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            out <= '0;
        end else begin
            a_q <= in;
            b_q <= a_q;
            s_q <= S;
            out <= alu_res;
        end
    end

endmodule

// File: tb/tb_test_frequency.sv
module tb_test_frequency;

    logic       clock;
    logic       reset;
    logic [4:0] in;
    logic [3:0] S;
    logic [9:0] out;

    int total = 0;
    int bad   = 0;
    int hin[$];
    int hs[$];
    int got;

    test_frequency dut (
        .clock (clock),
        .reset (reset),
        .in    (in),
        .S     (S),
        .out   (out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference ALU in plain integer arithmetic, results reduced mod 1024.
    function automatic int ref_alu(input int a, input int b, input int s);
        int sh;
        sh = b % 8;
        case (s)
            0:  return (a + b) % 1024;
            1:  return (a - b + 1024) % 1024;
            2:  return (a * b) % 1024;
            3:  return a & b;
            4:  return a | b;
            5:  return a ^ b;
            6:  return 31 - (a & b);
            7:  return 31 - (a | b);
            8:  return 31 - (a ^ b);
            9:  return (a * (1 << sh)) % 1024;
            10: return a / (1 << sh);
            11: return 31 - a;
            12: return a;
            13: return b;
            14: return (a < b) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int hist_in(input int idx);
        return (idx < 0) ? 0 : hin[idx];
    endfunction

    function automatic int hist_s(input int idx);
        return (idx < 0) ? 0 : hs[idx];
    endfunction

    // Called in the low clock phase; returns in the next low phase.
    task automatic step(input int in_v, input int s_v, input string tag);
        int n;
        in = 5'(in_v);
        S  = 4'(s_v);
        @(posedge clock);
        #1;
        hin.push_back(in_v);
        hs.push_back(s_v);
        n = hin.size();
        got = int'(out);
        chk(tag, got, ref_alu(hist_in(n-2), hist_in(n-3), hist_s(n-2)));
        @(negedge clock);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1 chk("rst_async", int'(out), 0);
        @(posedge clock);
        #1 chk("rst_hold", int'(out), 0);
        @(negedge clock);
        reset = 1'b1;
        hin.delete();
        hs.delete();
    endtask

    initial begin
        reset = 1'b0;
        in    = '0;
        S     = '0;
        #1 chk("rst_init", int'(out), 0);
        @(negedge clock);
        reset = 1'b1;

        step(2, 0, "first_edge");
        chk("first_zero", got, 0);
        step(1, 0, "add_m");
        step(0, 0, "add_m");
        chk("add_3", got, 3);

        do_reset();
        step(2, 1, "sub_m");
        step(1, 1, "sub_m");
        step(0, 1, "sub_m");
        chk("sub_wrap", got, 1023);

        do_reset();
        step(31, 2, "mul_m");
        step(31, 2, "mul_m");
        step(0, 2, "mul_m");
        chk("mul_max", got, 961);

        do_reset();
        step(7, 9, "shl_m");
        step(31, 9, "shl_m");
        step(0, 9, "shl_m");
        chk("shl_trunc", got, 896);

        do_reset();
        step(15, 0, "pipe_m");
        step(21, 3, "pipe_m");
        step(15, 4, "pipe_m");
        chk("pipe_and", got, 5);
        step(21, 5, "pipe_m");
        chk("pipe_or", got, 31);
        step(0, 0, "pipe_m");
        chk("pipe_xor", got, 26);

        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 96)
                do_reset();
            else
                step(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
